// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - RV32I control encodings, control bundle and shared decoder
//
// Purpose: shared by the pipelined decode stage and the single-cycle core.
//   alu_op_e / br_type_e / wb_sel_e : control-field encodings
//   imm_fmt_e                       : immediate format select for rv_imm_gen
//   ctrl_t                          : control bundle held in the ID/EX register
//   dec_t                           : decoder result (ctrl_t + immediate format + source-register use)
//   rv_decode()                     : combinational decoder (opcode, funct3, funct7, enable_mul)
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SLL    = 4'b0001,
        ALU_XOR    = 4'b0010,
        ALU_SRL    = 4'b0011,
        ALU_SRA    = 4'b0100,
        ALU_OR     = 4'b0101,
        ALU_AND    = 4'b0110,
        ALU_SUB    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASSB  = 4'b1010,
        ALU_MUL    = 4'b1011,
        ALU_MULH   = 4'b1100,
        ALU_MULHSU = 4'b1101,
        ALU_MULHU  = 4'b1110
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b010,
        BR_BGE  = 3'b011,
        BR_BLTU = 3'b100,
        BR_BGEU = 3'b101,
        BR_NONE = 3'b110,
        BR_JUMP = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        WB_PC4 = 2'b00,
        WB_ALU = 2'b01,
        WB_MEM = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // sel_a: 1 = rs1, 0 = PC.  sel_b: 1 = immediate, 0 = rs2.
    typedef struct packed {
        alu_op_e  alu_op;
        br_type_e br_type;
        wb_sel_e  wb_sel;
        logic     reg_wr;
        logic     sel_a;
        logic     sel_b;
        logic     wr_en;
        logic     rd_en;
        logic     unsign;
        logic     illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t    ctrl;
        imm_fmt_e imm_fmt;
        logic     use_rs1;
        logic     use_rs2;
    } dec_t;

    localparam ctrl_t CTRL_RESET = '{
        alu_op:  ALU_ADD,
        br_type: BR_NONE,
        wb_sel:  WB_PC4,
        reg_wr:  1'b0,
        sel_a:   1'b0,
        sel_b:   1'b0,
        wr_en:   1'b0,
        rd_en:   1'b0,
        unsign:  1'b0,
        illegal: 1'b0
    };

    // funct3 -> ALU op for the base OP / OP-IMM group (funct7 = 0000000).
    function automatic alu_op_e alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t rv_decode(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7,
                                       input logic       enable_mul);
        dec_t d;
        d.ctrl    = CTRL_RESET;
        d.imm_fmt = IMM_I;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.use_rs1       = 1'b1;
                d.use_rs2       = 1'b1;
                d.ctrl.sel_a    = 1'b1;
                d.ctrl.reg_wr   = 1'b1;
                d.ctrl.wb_sel   = WB_ALU;
                if (funct7 == F7_BASE) begin
                    d.ctrl.alu_op = alu_base(funct3);
                    d.ctrl.unsign = (funct3 == 3'b011);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      d.ctrl.alu_op  = ALU_SUB;
                    else if (funct3 == 3'b101) d.ctrl.alu_op  = ALU_SRA;
                    else                       d.ctrl.illegal = 1'b1;
                end else if (funct7 == F7_MUL && enable_mul && !funct3[2]) begin
                    case (funct3[1:0])
                        2'b00:   d.ctrl.alu_op = ALU_MUL;
                        2'b01:   d.ctrl.alu_op = ALU_MULH;
                        2'b10:   d.ctrl.alu_op = ALU_MULHSU;
                        default: d.ctrl.alu_op = ALU_MULHU;
                    endcase
                end else begin
                    d.ctrl.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d.use_rs1     = 1'b1;
                d.ctrl.sel_a  = 1'b1;
                d.ctrl.sel_b  = 1'b1;
                d.ctrl.reg_wr = 1'b1;
                d.ctrl.wb_sel = WB_ALU;
                d.ctrl.alu_op = alu_base(funct3);
                d.ctrl.unsign = (funct3 == 3'b011);
                // funct7 only carries meaning for the shift-immediate forms.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    d.ctrl.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       d.ctrl.alu_op  = ALU_SRA;
                    else if (funct7 != F7_BASE) d.ctrl.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                d.use_rs1      = 1'b1;
                d.ctrl.sel_a   = 1'b1;
                d.ctrl.sel_b   = 1'b1;
                d.ctrl.rd_en   = 1'b1;
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.wb_sel  = WB_MEM;
                d.ctrl.unsign  = funct3[2];
                d.ctrl.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.use_rs1      = 1'b1;
                d.use_rs2      = 1'b1;
                d.imm_fmt      = IMM_S;
                d.ctrl.sel_a   = 1'b1;
                d.ctrl.sel_b   = 1'b1;
                d.ctrl.wr_en   = 1'b1;
                d.ctrl.illegal = funct3[2] || (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                d.use_rs1     = 1'b1;
                d.use_rs2     = 1'b1;
                d.imm_fmt     = IMM_B;
                d.ctrl.sel_b  = 1'b1;
                d.ctrl.unsign = funct3[2] && funct3[1];
                case (funct3)
                    3'b000:  d.ctrl.br_type = BR_BEQ;
                    3'b001:  d.ctrl.br_type = BR_BNE;
                    3'b100:  d.ctrl.br_type = BR_BLT;
                    3'b101:  d.ctrl.br_type = BR_BGE;
                    3'b110:  d.ctrl.br_type = BR_BLTU;
                    3'b111:  d.ctrl.br_type = BR_BGEU;
                    default: d.ctrl.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d.imm_fmt      = IMM_J;
                d.ctrl.sel_b   = 1'b1;
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.br_type = BR_JUMP;
            end
            OPC_JALR: begin
                d.use_rs1      = 1'b1;
                d.ctrl.sel_a   = 1'b1;
                d.ctrl.sel_b   = 1'b1;
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.br_type = BR_JUMP;
                d.ctrl.illegal = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                d.imm_fmt     = IMM_U;
                d.ctrl.sel_b  = 1'b1;
                d.ctrl.reg_wr = 1'b1;
                d.ctrl.wb_sel = WB_ALU;
                d.ctrl.alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                d.imm_fmt     = IMM_U;
                d.ctrl.sel_b  = 1'b1;
                d.ctrl.reg_wr = 1'b1;
                d.ctrl.wb_sel = WB_ALU;
            end
            default: begin
                d.ctrl.illegal = 1'b1;
            end
        endcase
        // An illegal instruction must have no architectural side effects downstream.
        if (d.ctrl.illegal) begin
            d.ctrl.reg_wr  = 1'b0;
            d.ctrl.wr_en   = 1'b0;
            d.ctrl.rd_en   = 1'b0;
            d.ctrl.br_type = BR_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational RV32I immediate generator
//
// Purpose: builds the sign-extended 32-bit immediate for the selected format.
// Ports:
//   instr_i [31:7] : instruction word (opcode bits carry no immediate data)
//   fmt_i          : immediate format (I/S/B/U/J)
//   imm_o   [31:0] : immediate
module rv_imm_gen
    import rv_ctrl_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered, handshaked RV32I decode stage with load-use interlock
//
// Purpose: decodes the offered instruction and holds it in the ID/EX register.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc : fetch-side handshake and payload
//   flush                        : discard held and offered instructions
//   out_valid/out_ready          : execute-side handshake
//   out_pc, out_rs1/rs2/rd, out_imm, out_alu_op, out_br_type, out_wb_sel,
//   out_reg_wr, out_sel_a, out_sel_b, out_wr_en, out_rd_en, out_unsign, out_illegal
//                                : registered decode result
//   stall_cnt                    : saturating count of load-use stall cycles
module rv_decode_stage
    import rv_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter bit ENABLE_MUL = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_br_type,
    output logic [1:0]       out_wb_sel,
    output logic             out_reg_wr,
    output logic             out_sel_a,
    output logic             out_sel_b,
    output logic             out_wr_en,
    output logic             out_rd_en,
    output logic             out_unsign,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    dec_t              dec;
    logic [31:0]       imm;
    logic              rs1_hit, rs2_hit, hazard, accept;

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0]       imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign dec = rv_decode(in_instr[6:0], in_instr[14:12], in_instr[31:25], ENABLE_MUL);

    rv_imm_gen u_imm_gen (
        .instr_i (in_instr[31:7]),
        .fmt_i   (dec.imm_fmt),
        .imm_o   (imm)
    );

    // Load-use: the held load's data is not available for an immediately following reader.
    assign rs1_hit = dec.use_rs1 && (in_instr[19:15] == rd_q);
    assign rs2_hit = dec.use_rs2 && (in_instr[24:20] == rd_q);
    assign hazard  = valid_q && ctrl_q.rd_en && (rd_q != 5'd0) && in_valid && (rs1_hit || rs2_hit);

    // Flush overrides the interlock and swallows the offered instruction.
    assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        stall_d = stall_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            rs1_d   = in_instr[19:15];
            rs2_d   = in_instr[24:20];
            rd_d    = in_instr[11:7];
            imm_d   = imm;
            ctrl_d  = dec.ctrl;
        end else if (out_ready) begin
            // Held instruction consumed with nothing to replace it: bubble.
            valid_d = 1'b0;
        end
        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= CTRL_RESET;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd      = rd_q;
    assign out_imm     = imm_q;
    assign out_alu_op  = ctrl_q.alu_op;
    assign out_br_type = ctrl_q.br_type;
    assign out_wb_sel  = ctrl_q.wb_sel;
    assign out_reg_wr  = ctrl_q.reg_wr;
    assign out_sel_a   = ctrl_q.sel_a;
    assign out_sel_b   = ctrl_q.sel_b;
    assign out_wr_en   = ctrl_q.wr_en;
    assign out_rd_en   = ctrl_q.rd_en;
    assign out_unsign  = ctrl_q.unsign;
    assign out_illegal = ctrl_q.illegal;
    assign stall_cnt   = stall_q;

endmodule
